// File: rtl/pixel_assembler_pkg.sv
// Shared types and helpers for the byte-to-pixel stage and downstream window stages.
package pixel_assembler_pkg;

  typedef enum logic {
    hi_s = 1'b0,
    lo_s = 1'b1
  } byte_phase_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  localparam int unsigned byte_w_lp   = 8;
  localparam int unsigned pixel_w_lp  = 16;
  localparam int unsigned resync_w_lp = 16;

  // Counter width for a dimension of n positions (never narrower than 1 bit).
  function automatic int unsigned cnt_width_f(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pixel_assembler_if.sv
// Byte-stream input and tagged-pixel output handshakes of the pixel assembler.
interface pixel_assembler_if
  import pixel_assembler_pkg::*;
#(
  parameter int unsigned frame_width_p  = 320,
  parameter int unsigned frame_height_p = 240
);
  localparam int unsigned x_w_lp = cnt_width_f(frame_width_p);
  localparam int unsigned y_w_lp = cnt_width_f(frame_height_p);

  logic [byte_w_lp-1:0]  data_i;
  logic                  sof_i;
  logic                  valid_i;
  logic                  ready_o;
  logic [pixel_w_lp-1:0] data_o;
  logic [x_w_lp-1:0]     x_o;
  logic [y_w_lp-1:0]     y_o;
  logic                  eol_o;
  logic                  eof_o;
  logic                  valid_o;
  logic                  ready_i;

  // Source of bytes / sink of pixels.
  modport master (
    output data_i, sof_i, valid_i, ready_i,
    input  ready_o, data_o, x_o, y_o, eol_o, eof_o, valid_o
  );

  // The assembler itself.
  modport slave (
    input  data_i, sof_i, valid_i, ready_i,
    output ready_o, data_o, x_o, y_o, eol_o, eof_o, valid_o
  );

endinterface

// File: rtl/pixel_assembler_frame_counter.sv
// x/y raster position counters with clear, increment and last-column/last-row compares.
module frame_counter
  import pixel_assembler_pkg::*;
#(
  parameter int unsigned width_p  = 320,
  parameter int unsigned height_p = 240,
  localparam int unsigned x_w_lp  = cnt_width_f(width_p),
  localparam int unsigned y_w_lp  = cnt_width_f(height_p)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clear_i,
  input  logic              inc_i,
  output logic [x_w_lp-1:0] x_o,
  output logic [y_w_lp-1:0] y_o,
  output logic              last_x_c,
  output logic              last_y_c
);

  assign last_x_c = (x_o == x_w_lp'(width_p - 1));
  assign last_y_c = (y_o == y_w_lp'(height_p - 1));

  // Raster advance: x wraps into y, y wraps at end of frame; clear wins over increment.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      x_o <= '0;
      y_o <= '0;
    end else if (inc_i) begin
      if (last_x_c) begin
        x_o <= '0;
        y_o <= last_y_c ? '0 : y_o + y_w_lp'(1);
      end else begin
        x_o <= x_o + x_w_lp'(1);
      end
    end
  end

endmodule

// File: rtl/pixel_assembler.sv
// Packs byte pairs (high byte first) into RGB565 pixels tagged with x/y, eol and eof.
// Optional build macro PIXEL_ASSEMBLER_ERR_EN adds resync_count_o, a saturating
// count of start-of-frame bytes that arrive off the natural pixel (0,0) boundary.
module pixel_assembler
  import pixel_assembler_pkg::*;
#(
  parameter int unsigned frame_width_p    = 320,
  parameter int unsigned frame_height_p   = 240,
  parameter int unsigned datapath_reset_p = 0
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  pixel_assembler_if.slave       bus
`ifdef PIXEL_ASSEMBLER_ERR_EN
  ,
  output logic [resync_w_lp-1:0] resync_count_o
`endif
);

  localparam int unsigned x_w_lp = cnt_width_f(frame_width_p);
  localparam int unsigned y_w_lp = cnt_width_f(frame_height_p);

  byte_phase_e          state_q, state_d;
  logic [byte_w_lp-1:0] hold_q;
  logic                 accept;
  logic                 hold_ld, pix_ld, cnt_clr, cnt_inc;
  logic [x_w_lp-1:0]    x_cnt;
  logic [y_w_lp-1:0]    y_cnt;
  logic                 last_x, last_y;
  rgb565_t              pix_d;

  // Only the pixel register can stall the input, and only while a low byte is due.
  assign bus.ready_o = (state_q == hi_s) || !bus.valid_o || bus.ready_i;
  assign accept      = bus.valid_i && bus.ready_o && !reset_i;
  assign pix_d       = rgb565_t'({hold_q, bus.data_i});

  frame_counter #(
    .width_p  (frame_width_p),
    .height_p (frame_height_p)
  ) u_frame_counter (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clear_i  (cnt_clr),
    .inc_i    (cnt_inc),
    .x_o      (x_cnt),
    .y_o      (y_cnt),
    .last_x_c (last_x),
    .last_y_c (last_y)
  );

  // Byte-phase state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= hi_s;
    else         state_q <= state_d;
  end

  // Next phase and load strobes; a start-of-frame byte always restarts as a high byte.
  always_comb begin
    state_d = state_q;
    hold_ld = 1'b0;
    pix_ld  = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (accept) begin
      if (bus.sof_i) begin
        hold_ld = 1'b1;
        cnt_clr = 1'b1;
        state_d = lo_s;
      end else begin
        unique case (state_q)
          hi_s: begin
            hold_ld = 1'b1;
            state_d = lo_s;
          end
          lo_s: begin
            pix_ld  = 1'b1;
            cnt_inc = 1'b1;
            state_d = hi_s;
          end
          default: state_d = hi_s;
        endcase
      end
    end
  end

  // High-byte holding register.
  always_ff @(posedge clk_i) begin
    if (reset_i && (datapath_reset_p != 0)) hold_q <= '0;
    else if (hold_ld)                       hold_q <= bus.data_i;
  end

  // Pixel data register.
  always_ff @(posedge clk_i) begin
    if (reset_i && (datapath_reset_p != 0)) bus.data_o <= '0;
    else if (pix_ld)                        bus.data_o <= pix_d;
  end

  // Pixel valid and position tags; a new pixel may load in the same cycle the old one drains.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bus.valid_o <= 1'b0;
      bus.x_o     <= '0;
      bus.y_o     <= '0;
      bus.eol_o   <= 1'b0;
      bus.eof_o   <= 1'b0;
    end else if (pix_ld) begin
      bus.valid_o <= 1'b1;
      bus.x_o     <= x_cnt;
      bus.y_o     <= y_cnt;
      bus.eol_o   <= last_x;
      bus.eof_o   <= last_x && last_y;
    end else if (bus.ready_i) begin
      bus.valid_o <= 1'b0;
    end
  end

`ifdef PIXEL_ASSEMBLER_ERR_EN
  logic off_boundary;
  logic [resync_w_lp-1:0] resync_cnt_q;

  assign off_boundary   = accept && bus.sof_i &&
                          ((state_q == lo_s) || (x_cnt != '0) || (y_cnt != '0));
  assign resync_count_o = resync_cnt_q;

  // Saturating count of start-of-frame bytes that break into a frame.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      resync_cnt_q <= '0;
    else if (off_boundary && (resync_cnt_q != {resync_w_lp{1'b1}}))
      resync_cnt_q <= resync_cnt_q + resync_w_lp'(1);
  end
`endif

endmodule

// File: tb/tb_pixel_assembler.sv
// Directed, table-driven bench for pixel_assembler on a 4x2 frame.
module tb_pixel_assembler;
  import pixel_assembler_pkg::*;

  localparam int unsigned W = 4;
  localparam int unsigned H = 2;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        sof;
    logic        rdy;
    logic        e_rdy;
    logic        e_v;
    logic [15:0] e_d;
    logic [7:0]  e_x;
    logic [7:0]  e_y;
    logic        e_eol;
    logic        e_eof;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs[$];

  pixel_assembler_if #(.frame_width_p(W), .frame_height_p(H)) bus ();

`ifdef PIXEL_ASSEMBLER_ERR_EN
  logic [15:0] resync_count;
`endif

  pixel_assembler #(
    .frame_width_p    (W),
    .frame_height_p   (H),
    .datapath_reset_p (0)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
`ifdef PIXEL_ASSEMBLER_ERR_EN
    ,
    .resync_count_o (resync_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic add(input logic v, input logic [7:0] d, input logic sof, input logic rdy,
                     input logic e_rdy, input logic e_v, input logic [15:0] e_d,
                     input logic [7:0] e_x, input logic [7:0] e_y,
                     input logic e_eol, input logic e_eof);
    vec_t t;
    t.v = v; t.d = d; t.sof = sof; t.rdy = rdy; t.e_rdy = e_rdy; t.e_v = e_v;
    t.e_d = e_d; t.e_x = e_x; t.e_y = e_y; t.e_eol = e_eol; t.e_eof = e_eof;
    vecs.push_back(t);
  endtask

  // Compare the registered outputs; payload fields only matter while valid_o is expected high.
  task automatic check_out(input string name, input logic e_v, input logic [15:0] e_d,
                           input logic [7:0] e_x, input logic [7:0] e_y,
                           input logic e_eol, input logic e_eof);
    logic bad;
    n_vec++;
    bad = (bus.valid_o !== e_v);
    if (e_v && ((bus.data_o !== e_d) || (8'(bus.x_o) !== e_x) || (8'(bus.y_o) !== e_y) ||
                (bus.eol_o !== e_eol) || (bus.eof_o !== e_eof)))
      bad = 1'b1;
    if (bad) begin
      n_err++;
      $display("FAIL %s: got v=%0b d=%h x=%0d y=%0d eol=%0b eof=%0b want v=%0b d=%h x=%0d y=%0d eol=%0b eof=%0b",
               name, bus.valid_o, bus.data_o, bus.x_o, bus.y_o, bus.eol_o, bus.eof_o,
               e_v, e_d, e_x, e_y, e_eol, e_eof);
    end
  endtask

  // One cycle: drive inputs, check ready_o before the edge, check outputs after it.
  task automatic apply(input string name, input vec_t t);
    bus.valid_i = t.v;
    bus.data_i  = t.d;
    bus.sof_i   = t.sof;
    bus.ready_i = t.rdy;
    #3;
    n_vec++;
    if (bus.ready_o !== t.e_rdy) begin
      n_err++;
      $display("FAIL %s ready_o: got %0b want %0b", name, bus.ready_o, t.e_rdy);
    end
    @(posedge clk);
    #1;
    check_out(name, t.e_v, t.e_d, t.e_x, t.e_y, t.e_eol, t.e_eof);
  endtask

  task automatic step(input string name, input logic v, input logic [7:0] d, input logic sof,
                      input logic rdy, input logic e_rdy, input logic e_v, input logic [15:0] e_d,
                      input logic [7:0] e_x, input logic [7:0] e_y,
                      input logic e_eol, input logic e_eof);
    vec_t t;
    t.v = v; t.d = d; t.sof = sof; t.rdy = rdy; t.e_rdy = e_rdy; t.e_v = e_v;
    t.e_d = e_d; t.e_x = e_x; t.e_y = e_y; t.e_eol = e_eol; t.e_eof = e_eof;
    apply(name, t);
  endtask

`ifdef PIXEL_ASSEMBLER_ERR_EN
  task automatic check_resync(input string name, input logic [15:0] exp);
    n_vec++;
    if (resync_count !== exp) begin
      n_err++;
      $display("FAIL %s: resync_count_o got %h want %h", name, resync_count, exp);
    end
  endtask
`endif

  initial begin
    bus.valid_i = 1'b0;
    bus.data_i  = 8'h00;
    bus.sof_i   = 1'b0;
    bus.ready_i = 1'b1;

    // Full frame at one byte per cycle, then restart of the next frame.
    add(1, 8'h12, 1, 1, 1, 0, 16'h0000, 0, 0, 0, 0);
    add(1, 8'h34, 0, 1, 1, 1, 16'h1234, 0, 0, 0, 0);
    add(1, 8'h56, 0, 1, 1, 0, 16'h0000, 0, 0, 0, 0);
    add(1, 8'h78, 0, 1, 1, 1, 16'h5678, 1, 0, 0, 0);
    add(1, 8'h9A, 0, 1, 1, 0, 16'h0000, 0, 0, 0, 0);
    add(1, 8'hBC, 0, 1, 1, 1, 16'h9ABC, 2, 0, 0, 0);
    add(1, 8'hDE, 0, 1, 1, 0, 16'h0000, 0, 0, 0, 0);
    add(1, 8'hF0, 0, 1, 1, 1, 16'hDEF0, 3, 0, 1, 0);
    add(1, 8'h11, 0, 1, 1, 0, 16'h0000, 0, 0, 0, 0);
    add(1, 8'h22, 0, 1, 1, 1, 16'h1122, 0, 1, 0, 0);
    add(1, 8'h33, 0, 1, 1, 0, 16'h0000, 0, 0, 0, 0);
    add(1, 8'h44, 0, 1, 1, 1, 16'h3344, 1, 1, 0, 0);
    add(1, 8'h55, 0, 1, 1, 0, 16'h0000, 0, 0, 0, 0);
    add(1, 8'h66, 0, 1, 1, 1, 16'h5566, 2, 1, 0, 0);
    add(1, 8'h77, 0, 1, 1, 0, 16'h0000, 0, 0, 0, 0);
    add(1, 8'h88, 0, 1, 1, 1, 16'h7788, 3, 1, 1, 1);
    add(1, 8'hA1, 1, 1, 1, 0, 16'h0000, 0, 0, 0, 0);
    add(1, 8'hA2, 0, 1, 1, 1, 16'hA1A2, 0, 0, 0, 0);
    // Backpressure: high byte still accepted, low byte stalls, then drain and load together.
    add(1, 8'hB1, 0, 0, 1, 1, 16'hA1A2, 0, 0, 0, 0);
    add(1, 8'hB2, 0, 0, 0, 1, 16'hA1A2, 0, 0, 0, 0);
    add(1, 8'hB2, 0, 0, 0, 1, 16'hA1A2, 0, 0, 0, 0);
    add(1, 8'hB2, 0, 1, 1, 1, 16'hB1B2, 1, 0, 0, 0);
    add(0, 8'h00, 0, 1, 1, 0, 16'h0000, 0, 0, 0, 0);
    // Mid-pixel resync: 0xAB discarded, 0xCD becomes the high byte of (0,0).
    add(1, 8'hAB, 0, 1, 1, 0, 16'h0000, 0, 0, 0, 0);
    add(1, 8'hCD, 1, 1, 1, 0, 16'h0000, 0, 0, 0, 0);
    add(1, 8'hEF, 0, 1, 1, 1, 16'hCDEF, 0, 0, 0, 0);
    add(0, 8'h00, 0, 1, 1, 0, 16'h0000, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_out("reset_state", 0, 16'h0000, 0, 0, 0, 0);
    n_vec++;
    if ((bus.ready_o !== 1'b1) || (bus.x_o !== '0) || (bus.y_o !== '0) ||
        (bus.eol_o !== 1'b0) || (bus.eof_o !== 1'b0)) begin
      n_err++;
      $display("FAIL reset_tags: got rdy=%0b x=%0d y=%0d eol=%0b eof=%0b want 1 0 0 0 0",
               bus.ready_o, bus.x_o, bus.y_o, bus.eol_o, bus.eof_o);
    end

    foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

`ifdef PIXEL_ASSEMBLER_ERR_EN
    check_resync("resync_after_midpixel_sof", 16'h0001);
`endif

    // Reset while a pixel is held and a high byte is pending.
    step("rst_pre_hi",  1, 8'h11, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 0);
    step("rst_pre_lo",  1, 8'h22, 0, 0, 1, 1, 16'h1122, 1, 0, 0, 0);
    step("rst_pre_hold",1, 8'h33, 0, 0, 1, 1, 16'h1122, 1, 0, 0, 0);
    bus.valid_i = 1'b1;
    bus.data_i  = 8'h44;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_out("rst_drop", 0, 16'h0000, 0, 0, 0, 0);
    n_vec++;
    if ((bus.x_o !== '0) || (bus.y_o !== '0)) begin
      n_err++;
      $display("FAIL rst_tags: got x=%0d y=%0d want 0 0", bus.x_o, bus.y_o);
    end
`ifdef PIXEL_ASSEMBLER_ERR_EN
    check_resync("resync_after_reset", 16'h0000);
`endif
    step("post_rst_hi", 1, 8'h55, 0, 1, 1, 0, 16'h0000, 0, 0, 0, 0);
    step("post_rst_lo", 1, 8'h66, 0, 1, 1, 1, 16'h5566, 0, 0, 0, 0);
    step("post_rst_sof",1, 8'h77, 1, 1, 1, 0, 16'h0000, 0, 0, 0, 0);
    step("post_rst_px", 1, 8'h88, 0, 1, 1, 1, 16'h7788, 0, 0, 0, 0);
`ifdef PIXEL_ASSEMBLER_ERR_EN
    check_resync("resync_offboundary_sof", 16'h0001);
    force dut.resync_cnt_q = 16'hFFFE;
    #1 release dut.resync_cnt_q;
    step("sat_sof0", 1, 8'hAA, 1, 1, 1, 0, 16'h0000, 0, 0, 0, 0);
    step("sat_sof1", 1, 8'hBB, 1, 1, 1, 0, 16'h0000, 0, 0, 0, 0);
    step("sat_sof2", 1, 8'hCC, 1, 1, 1, 0, 16'h0000, 0, 0, 0, 0);
    check_resync("resync_saturated", 16'hFFFF);
`endif
    bus.valid_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_assembler.md
Name: pixel_assembler

Overview:
Byte-to-pixel stage at the head of the vision pipeline. Consumes the 8-bit camera/link byte stream and packs byte pairs into RGB565 pixels, high byte first. Tags each pixel with x/y position and end-of-line/end-of-frame flags. Presents the result on a registered valid/ready output that feeds the downstream elastic buffer stage.

Parameters:
frame_width_p, 320, pixels per line (>=2)
frame_height_p, 240, lines per frame (>=2)
datapath_reset_p, 0, 1 = data_o/hold byte cleared on reset; 0 = datapath not reset

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
data_i  in  8  input byte
sof_i  in  1  start-of-frame marker; qualified by the input handshake
valid_i  in  1  byte valid
ready_o  out  1  byte accepted when valid_i && ready_o
data_o  out  16  RGB565 pixel {hi_byte, lo_byte}
x_o  out  $clog2(frame_width_p)  column of data_o
y_o  out  $clog2(frame_height_p)  row of data_o
eol_o  out  1  data_o is the last pixel of its line
eof_o  out  1  data_o is the last pixel of the frame
valid_o  out  1  pixel valid
ready_i  in  1  downstream ready

Behaviour:
- Clock and reset: one clock, clk_i. reset_i is synchronous and active-high.
- Byte-phase FSM: hi_s = expecting high byte; lo_s = expecting low byte.
  - Reset: state hi_s, valid_o=0, x/y counters 0, eol_o=0, eof_o=0.
  - data_o and the hold byte are cleared on reset only if datapath_reset_p=1; otherwise they are don't-care until the first pixel.
- ready_o = (state==hi_s) || !valid_o || ready_i. This is combinational from state and ready_i; there is no combinational path from valid_i to ready_o.
- hi_s, byte accepted: store the byte in the hold register and go to lo_s. The output register is untouched.
- lo_s, byte accepted:
  - Load data_o={hold,data_i}, x_o=x_cnt, y_o=y_cnt, eol_o=(x_cnt==W-1), eof_o=eol_o&&(y_cnt==H-1).
  - Set valid_o=1 and go to hi_s.
  - Advance counters: x wraps to 0 at W-1 and increments y; y wraps to 0 at H-1.
- Latency: a pixel is visible on valid_o the cycle after its low byte is accepted. One pixel per two accepted bytes. Full throughput is 1 byte/cycle with ready_i held at 1.
- Output hold: valid_o stays high and data_o/x_o/y_o/eol_o/eof_o stay stable until valid_o&&ready_i. On that cycle valid_o clears, unless a new pixel loads in the same cycle, in which case it stays high with the new data.
- sof_i (honoured only on an accepted byte): the byte is always treated as the high byte of pixel (0,0).
  - Any half-assembled pixel in the hold register is discarded.
  - Counters are forced to 0 and the state goes to lo_s.
  - A pixel already in the output register is not affected.
- sof_i at the natural boundary (state hi_s, x=0, y=0) behaves exactly like a normal high byte.
- Reset mid-frame: the in-flight output pixel is dropped (valid_o=0 next cycle), and the hold byte and counters are abandoned.

Optional Feature:
PIXEL_ASSEMBLER_ERR_EN
- Defined: adds output port resync_count_o (16 bits).
  - Saturating count of accepted sof_i bytes arriving off-boundary: state==lo_s, or x_cnt!=0, or y_cnt!=0.
  - Reset to 0; holds at 16'hFFFF when saturated.
- Undefined: port absent. sof_i resync behaviour is unchanged and no counter logic is present.

Decomposition:
- pixel_pkg holds:
  - byte_phase_e enum {hi_s, lo_s}
  - rgb565_t packed struct {r[4:0], g[5:0], b[4:0]}
  - localparam function for counter width, shared with downstream window stages
- Sub-module frame_counter (params width/height): x/y counters with increment, clear, eol/eof compare. It is reused later by the line-buffer stage.

Test Plan:
- Frame 4x2, ready_i=1: bytes 0x12,0x34,… with sof on the first byte -> pixels 0x1234… at (0,0)…(3,1); eol_o on x=3; eof_o only on (3,1); next frame restarts at (0,0).
- Backpressure: ready_i=0 after the first pixel -> ready_o drops in lo_s once valid_o=1; data_o holds 0x1234 stable; no byte lost when ready_i returns.
- Simultaneous drain/load: ready_i=1 and the low byte accepted in the same cycle -> valid_o stays high, data_o updates next cycle, no bubble.
- Mid-pixel resync: in lo_s with hold=0xAB, send 0xCD with sof_i -> 0xAB is discarded; next byte 0xEF yields 0xCDEF at (0,0); ERR_EN build shows resync_count_o=1.
- Reset mid-frame with valid_o=1 -> valid_o=0 and counters at 0 next cycle; a following sof sequence produces the correct (0,0) pixel.
- ERR_EN saturation: force the counter near 16'hFFFF and apply 3 off-boundary sofs -> the count stays at 16'hFFFF.
